// File: rtl/mem_byte_port_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// mem_pkg : funct3 codes, FSM states and request-decode helpers. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DRAIN  = 2'd2,
    RESP   = 2'd3
  } state_t;

  // Unsigned widths only make sense for loads.
  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    case (f3)
      F3_B, F3_H, F3_W: return 1'b1;
      F3_BU, F3_HU:     return !we;
      default:          return 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] f3_last_idx(input logic [2:0] f3);
    case (f3[1:0])
      2'b01:   return 2'd1;
      2'b10:   return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_byte_port_ctrl_if.sv
// ----------------------------------------------------------------------------
// mem_byte_port_ctrl_if : core-side request/response bus. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface mem_byte_port_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

`default_nettype wire

// File: rtl/mem_byte_port_ctrl_load_ext.sv
// ----------------------------------------------------------------------------
// mem_load_ext : sign/zero extension of assembled load bytes. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mem_load_ext
  import mem_pkg::*;
(
  input  logic [31:0] raw,
  input  logic [2:0]  funct3,
  output logic [31:0] ext
);

  always_comb begin
    ext = raw;
    case (funct3)
      F3_B:    ext = {{24{raw[7]}}, raw[7:0]};
      F3_BU:   ext = {24'd0, raw[7:0]};
      F3_H:    ext = {{16{raw[15]}}, raw[15:0]};
      F3_HU:   ext = {16'd0, raw[15:0]};
      default: ext = raw;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_byte_port_ctrl.sv
// ----------------------------------------------------------------------------
// mem_byte_port_ctrl : serialises RV32I loads/stores into byte-RAM accesses. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mem_byte_port_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_W = 23
) (
  input  logic                 clk,
  input  logic                 rst,
  mem_byte_port_ctrl_if.slave  bus,
  output logic                 ram_en,
  output logic                 ram_w_en,
  output logic [ADDR_W-1:0]    ram_addr,
  output logic [7:0]           ram_wdata,
  input  logic [7:0]           ram_rdata
);

  state_t              state_q, state_d;
  logic                we_q, we_d;
  logic [2:0]          f3_q, f3_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [1:0]          last_q, last_d;
  logic [1:0]          count_q, count_d;
  logic [31:0]         rbuf_q, rbuf_d;
  logic                err_q, err_d;

  logic                req_ready_q, req_ready_d;
  logic                ram_en_q, ram_en_d;
  logic                ram_w_en_q, ram_w_en_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [7:0]          ram_wdata_q, ram_wdata_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [31:0]         rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;

  logic                bad_req;
  logic [31:0]         ext_w;

  assign bad_req = !f3_legal(bus.req_we, bus.req_funct3)
                 || (bus.req_funct3[1:0] == 2'b01 && bus.req_addr[0])
                 || (bus.req_funct3[1:0] == 2'b10 && bus.req_addr[1:0] != 2'b00)
                 || (|bus.req_addr[31:ADDR_W]);

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    last_d  = last_q;
    count_d = count_q;
    rbuf_d  = rbuf_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid && req_ready_q) begin
          we_d    = bus.req_we;
          f3_d    = bus.req_funct3;
          addr_d  = bus.req_addr[ADDR_W-1:0];
          wdata_d = bus.req_wdata;
          last_d  = f3_last_idx(bus.req_funct3);
          count_d = 2'd0;
          rbuf_d  = 32'd0;
          err_d   = bad_req;
          state_d = bad_req ? RESP : ACCESS;
        end
      end
      ACCESS: begin
        // Read data lags the address by one cycle, so lane count-1 lands now.
        if (!we_q && count_q != 2'd0)
          rbuf_d[{count_q - 2'd1, 3'b000} +: 8] = ram_rdata;
        if (count_q == last_q)
          state_d = we_q ? RESP : DRAIN;
        else
          count_d = count_q + 2'd1;
      end
      DRAIN: begin
        rbuf_d[{last_q, 3'b000} +: 8] = ram_rdata;
        state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  mem_load_ext u_load_ext (
    .raw    (rbuf_d),
    .funct3 (f3_d),
    .ext    (ext_w)
  );

  // Outputs are precomputed from the next state so every port is a flop.
  always_comb begin
    req_ready_d = (state_d == IDLE);
    ram_en_d    = (state_d == ACCESS);
    ram_w_en_d  = ram_en_d && we_d;
    ram_addr_d  = ram_en_d ? addr_d + {{(ADDR_W-2){1'b0}}, count_d} : '0;
    ram_wdata_d = ram_w_en_d ? wdata_d[{count_d, 3'b000} +: 8] : 8'd0;
    rsp_valid_d = (state_d == RESP);
    rsp_err_d   = rsp_valid_d && err_d;
    rsp_rdata_d = (rsp_valid_d && !err_d && !we_d) ? ext_w : 32'd0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      f3_q        <= 3'd0;
      addr_q      <= '0;
      wdata_q     <= 32'd0;
      last_q      <= 2'd0;
      count_q     <= 2'd0;
      rbuf_q      <= 32'd0;
      err_q       <= 1'b0;
      req_ready_q <= 1'b1;
      ram_en_q    <= 1'b0;
      ram_w_en_q  <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= 8'd0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      f3_q        <= f3_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      last_q      <= last_d;
      count_q     <= count_d;
      rbuf_q      <= rbuf_d;
      err_q       <= err_d;
      req_ready_q <= req_ready_d;
      ram_en_q    <= ram_en_d;
      ram_w_en_q  <= ram_w_en_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign ram_en        = ram_en_q;
  assign ram_w_en      = ram_w_en_q;
  assign ram_addr      = ram_addr_q;
  assign ram_wdata     = ram_wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_byte_port_ctrl.sv
// ----------------------------------------------------------------------------
// tb_mem_byte_port_ctrl : directed bench with a byte-RAM model. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_mem_byte_port_ctrl;
  localparam int ADDR_W = 23;

  logic              clk;
  logic              rst;
  logic              ram_en;
  logic              ram_w_en;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_wdata;
  logic [7:0]        ram_rdata;
  logic [7:0]        mem [256];

  int nvec;
  int nerr;
  int acc_cnt;
  int rsp_cnt;
  int en_cnt;

  mem_byte_port_ctrl_if bus ();

  mem_byte_port_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .ram_en    (ram_en),
    .ram_w_en  (ram_w_en),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  always #5 clk = ~clk;

  // Byte RAM with registered read, one-cycle latency.
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_w_en) mem[ram_addr[7:0]] <= ram_wdata;
      ram_rdata <= mem[ram_addr[7:0]];
    end
  end

  always @(posedge clk) begin
    if (bus.req_valid && bus.req_ready) acc_cnt <= acc_cnt + 1;
    if (bus.rsp_valid) rsp_cnt <= rsp_cnt + 1;
    if (ram_en) en_cnt <= en_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic req(input string tag, input logic we, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input int exp_lat, input logic exp_err, input logic [31:0] exp_rdata);
    int lat;
    int en0;
    logic [31:0] rd;
    logic er;
    lat = 0;
    rd  = 32'hX;
    er  = 1'bX;
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    @(posedge clk);
    en0 = en_cnt;
    #1 bus.req_valid = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        lat = k;
        rd  = bus.rsp_rdata;
        er  = bus.rsp_err;
        break;
      end
    end
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_err"}, {31'd0, er}, {31'd0, exp_err});
    chk({tag, "_rdata"}, rd, exp_rdata);
    @(negedge clk);
    chk({tag, "_pulse"}, {31'd0, bus.rsp_valid}, 32'd0);
    if (exp_err) chk({tag, "_noram"}, en_cnt - en0, 0);
  endtask

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    nvec = 0;
    nerr = 0;
    acc_cnt = 0;
    rsp_cnt = 0;
    en_cnt = 0;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'd0;
    bus.req_addr   = 32'd0;
    bus.req_wdata  = 32'd0;
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("rst_rspv", {31'd0, bus.rsp_valid}, 32'd0);
    chk("rst_ramen", {31'd0, ram_en}, 32'd0);
    chk("rst_rdata", bus.rsp_rdata, 32'd0);
    rst = 1'b0;

    req("sw10", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 5, 1'b0, 32'd0);
    chk("mem10", {24'd0, mem[8'h10]}, 32'hEF);
    chk("mem11", {24'd0, mem[8'h11]}, 32'hBE);
    chk("mem12", {24'd0, mem[8'h12]}, 32'hAD);
    chk("mem13", {24'd0, mem[8'h13]}, 32'hDE);
    req("lw10",  1'b0, 3'b010, 32'h10, 32'd0, 6, 1'b0, 32'hDEADBEEF);
    req("lb13",  1'b0, 3'b000, 32'h13, 32'd0, 3, 1'b0, 32'hFFFFFFDE);
    req("lbu13", 1'b0, 3'b100, 32'h13, 32'd0, 3, 1'b0, 32'h000000DE);
    req("lh12",  1'b0, 3'b001, 32'h12, 32'd0, 4, 1'b0, 32'hFFFFDEAD);
    req("lhu12", 1'b0, 3'b101, 32'h12, 32'd0, 4, 1'b0, 32'h0000DEAD);
    req("lb10",  1'b0, 3'b000, 32'h10, 32'd0, 3, 1'b0, 32'hFFFFFFEF);
    req("lh10",  1'b0, 3'b001, 32'h10, 32'd0, 4, 1'b0, 32'hFFFFBEEF);

    req("sw20",  1'b1, 3'b010, 32'h20, 32'h0, 5, 1'b0, 32'd0);
    req("sh20",  1'b1, 3'b001, 32'h20, 32'hCAFE1234, 3, 1'b0, 32'd0);
    req("lw20",  1'b0, 3'b010, 32'h20, 32'd0, 6, 1'b0, 32'h00001234);
    req("sb23",  1'b1, 3'b000, 32'h23, 32'h000000A5, 2, 1'b0, 32'd0);
    req("lw20b", 1'b0, 3'b010, 32'h20, 32'd0, 6, 1'b0, 32'hA5001234);

    req("e_lw11",  1'b0, 3'b010, 32'h11, 32'd0, 1, 1'b1, 32'd0);
    req("e_lh13",  1'b0, 3'b001, 32'h13, 32'd0, 1, 1'b1, 32'd0);
    req("e_f3011", 1'b0, 3'b011, 32'h10, 32'd0, 1, 1'b1, 32'd0);
    req("e_range", 1'b0, 3'b000, 32'h0080_0000, 32'd0, 1, 1'b1, 32'd0);
    req("e_sbu",   1'b1, 3'b100, 32'h10, 32'h0, 1, 1'b1, 32'd0);
    chk("e_keep13", {24'd0, mem[8'h13]}, 32'hDE);

    // Reset asserted while the third store byte is on the RAM port.
    req("sw40z", 1'b1, 3'b010, 32'h40, 32'h0, 5, 1'b0, 32'd0);
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_funct3 = 3'b010;
    bus.req_addr   = 32'h40;
    bus.req_wdata  = 32'h11223344;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rs_en_pre", {31'd0, ram_en}, 32'd1);
    chk("rs_addr_pre", {9'd0, ram_addr}, 32'h42);
    rst = 1'b1;
    #1;
    chk("rs_en_now", {31'd0, ram_en}, 32'd0);
    @(negedge clk);
    chk("rs_ready", {31'd0, bus.req_ready}, 32'd1);
    rst = 1'b0;
    chk("rs_mem40", {24'd0, mem[8'h40]}, 32'h44);
    chk("rs_mem41", {24'd0, mem[8'h41]}, 32'h33);
    chk("rs_mem42", {24'd0, mem[8'h42]}, 32'h00);
    req("rs_lw40", 1'b0, 3'b010, 32'h40, 32'd0, 6, 1'b0, 32'h00003344);

    // Continuous valid: LBU accepted every 4 cycles.
    @(negedge clk);
    acc_cnt = 0;
    rsp_cnt = 0;
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b100;
    bus.req_addr   = 32'h13;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.rsp_valid) chk("b2b_rdata", bus.rsp_rdata, 32'h000000DE);
    end
    bus.req_valid = 1'b0;
    repeat (8) @(negedge clk);
    chk("b2b_acc", acc_cnt, 5);
    chk("b2b_rsp", rsp_cnt, 5);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

`default_nettype wire
